arb_rr_n: RTL

//   N-way round-robin arbiter with registered one-hot grants and bounded grant tenure.

---
 rtl/arb_rr_n.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/arb_rr_n.sv
// ---------------------------------------------------------------------------
// arb_rr_n -- N-way round-robin arbiter with bounded grant tenure
//
// Grants a shared resource to one of N requesters. The grant is registered
// and one-hot. The owner keeps the resource for as long as it requests. If
// another requester is waiting, the owner is pre-empted after MAX_HOLD
// consecutive cycles. The next owner is found by scanning upward, modulo N,
// from the most recent owner. That owner is therefore always the
// lowest-priority candidate.
//
// Parameters
//   N         number of requesters (>= 2)
//   MAX_HOLD  maximum consecutive grant cycles while others wait (>= 1)
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active low
//   req        in   N    request vector, bit i = requester i wants the resource
//   gnt        out  N    registered one-hot grant, all-zero when idle
//   gnt_id     out  IDW  index of the current owner, 0 when idle
//   gnt_valid  out  1    high when a grant is active (|gnt)
// ---------------------------------------------------------------------------
module arb_rr_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    localparam int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t         state, state_d;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] gnt_id_d;
    logic [CW-1:0]  hold_cnt, hold_cnt_d;
    logic [IDW-1:0] last, last_d;
    logic [N-1:0]   others;
    logic [IDW-1:0] win_all, win_oth;

    // First set bit of r scanning p+1, p+2, ... (mod N).
    // Index p itself is visited last, so it is the lowest-priority candidate.
    // The scan steps through an int so that non-power-of-2 N wraps correctly.
    function automatic logic [IDW-1:0] next_winner(input logic [N-1:0]   r,
                                                   input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(p) + k) % N;
            if (!found && r[idx[IDW-1:0]]) begin
                found = 1'b1;
                w     = idx[IDW-1:0];
            end
        end
        return w;
    endfunction

    // While OWN, last equals the owner, so scanning from last is the same
    // as scanning from the owner. Masking the owner's own request out of
    // 'others' excludes it when the owner is pre-empted.
    assign others  = req & ~gnt;
    assign win_all = next_winner(req, last);
    assign win_oth = next_winner(others, last);

    always_comb begin
        state_d    = state;
        gnt_id_d   = gnt_id;
        hold_cnt_d = hold_cnt;
        last_d     = last;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_d    = OWN;
                    gnt_id_d   = win_all;
                    hold_cnt_d = CW'(1);
                    last_d     = win_all;
                end
            end
            OWN: begin
                if (!req[gnt_id]) begin
                    // Release: hand over in the same edge so no idle bubble appears.
                    if (|req) begin
                        gnt_id_d   = win_all;
                        hold_cnt_d = CW'(1);
                        last_d     = win_all;
                    end else begin
                        state_d    = IDLE;
                        gnt_id_d   = '0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt == CW'(MAX_HOLD) && |others) begin
                    gnt_id_d   = win_oth;
                    hold_cnt_d = CW'(1);
                    last_d     = win_oth;
                end else if (hold_cnt != CW'(MAX_HOLD)) begin
                    // Saturating count: a sole requester keeps the grant indefinitely.
                    hold_cnt_d = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_id_d   = '0;
                hold_cnt_d = '0;
            end
        endcase

        gnt_d = (state_d == OWN) ? (N'(1) << gnt_id_d) : '0;
    end

    // Registered grant state; req reaches the outputs only through these flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            last     <= IDW'(N - 1);
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            gnt_id   <= gnt_id_d;
            hold_cnt <= hold_cnt_d;
            last     <= last_d;
        end
    end

    assign gnt_valid = |gnt;

endmodule
